// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 key tracker: scan-code constants, the
// default tracked-key table, prefix bytes, FSM state types and a parity helper.
package ps2_pkg;

  // Tracked key entries are {ext, code}; ext marks an E0-prefixed key.
  localparam logic [8:0] KEY_ESC    = 9'h076;
  localparam logic [8:0] KEY_UP     = 9'h175;
  localparam logic [8:0] KEY_DOWN   = 9'h172;
  localparam logic [8:0] KEY_LEFT   = 9'h16B;
  localparam logic [8:0] KEY_RIGHT  = 9'h174;
  localparam logic [8:0] KEY_ENTER  = 9'h05A;
  localparam logic [8:0] KEY_SPACE  = 9'h029;
  localparam logic [8:0] KEY_W      = 9'h01D;
  localparam logic [8:0] KEY_A      = 9'h01C;
  localparam logic [8:0] KEY_S      = 9'h01B;
  localparam logic [8:0] KEY_D      = 9'h023;
  localparam logic [8:0] KEY_LSHIFT = 9'h012;

  // Index 0 is the rightmost element, so ESC is bit 0 and LSHIFT is bit 11.
  localparam logic [11:0][8:0] DEFAULT_KEY_MAP = {
    KEY_LSHIFT, KEY_D, KEY_S, KEY_A, KEY_W, KEY_SPACE,
    KEY_ENTER, KEY_RIGHT, KEY_LEFT, KEY_DOWN, KEY_UP, KEY_ESC
  };

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef enum logic [1:0] {F_IDLE, F_DATA, F_PARITY, F_STOP} frame_state_t;
  typedef enum logic [1:0] {D_IDLE, D_EXT, D_BRK, D_EXTBRK} dec_state_t;

  // Odd parity: the eight data bits together with the parity bit XOR to 1.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 byte receiver: line synchronisers, falling-edge detect, frame FSM and
// inter-edge watchdog. Emits a one-cycle byte strobe or error strobe.
// Optional feature macro: PS2_PARITY_CHECK_EN (parity mismatch rejects byte).
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 50_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       err
);

  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]      clk_sync, data_sync;
  logic            clk_hist;
  logic            fall, bit_in;
  frame_state_t    state, state_next;
  logic [7:0]      shift_reg;
  logic [2:0]      bit_cnt;
  logic            parity_bit;
  logic [WD_W-1:0] wd_cnt;
  logic            wd_hit;
  logic            parity_pass, stop_good;
  logic            shift_en, parity_en, byte_now, err_now;
  logic            err_q;

  // Bring the asynchronous PS/2 lines into the clk domain; idle line level is 1.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments let the sync chain shift one stage per clock;
    // blocking ones would collapse it into a single flop.
    if (rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_hist  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      clk_hist  <= clk_sync[1];
    end
  end

  assign fall   = clk_hist & ~clk_sync[1];
  assign bit_in = data_sync[1];
  assign wd_hit = (state != F_IDLE) && (wd_cnt == WD_W'(TIMEOUT_CYC));

`ifdef PS2_PARITY_CHECK_EN
  assign parity_pass = odd_parity_ok(shift_reg, parity_bit);
`else
  // Parity bit is still captured so the frame shape is unchanged; it is ignored.
  logic unused_parity_ok;
  assign unused_parity_ok = odd_parity_ok(shift_reg, parity_bit);
  assign parity_pass      = 1'b1;
`endif

  assign stop_good = bit_in & parity_pass;

  // Frame state register.
  always_ff @(posedge clk) begin
    if (rst) state <= F_IDLE;
    else     state <= state_next;
  end

  // Next frame state; a watchdog expiry abandons the frame regardless of edges.
  always_comb begin
    // NOTE: the default assignment first keeps this combinational block latch-free.
    state_next = state;
    if (wd_hit) begin
      state_next = F_IDLE;
    end else if (fall) begin
      case (state)
        F_IDLE:   if (!bit_in) state_next = F_DATA;
        F_DATA:   if (bit_cnt == 3'd7) state_next = F_PARITY;
        F_PARITY: state_next = F_STOP;
        F_STOP:   state_next = F_IDLE;
        default:  state_next = F_IDLE;
      endcase
    end
  end

  // Frame FSM outputs: datapath enables and the raw byte/error decisions.
  always_comb begin
    shift_en  = 1'b0;
    parity_en = 1'b0;
    byte_now  = 1'b0;
    err_now   = 1'b0;
    if (fall && !wd_hit) begin
      case (state)
        F_IDLE:   err_now   = bit_in;
        F_DATA:   shift_en  = 1'b1;
        F_PARITY: parity_en = 1'b1;
        F_STOP: begin
          byte_now = stop_good;
          err_now  = ~stop_good;
        end
        default: ;
      endcase
    end
  end

  // Shift register, bit counter, parity capture, watchdog and strobe registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg  <= 8'hFF;
      bit_cnt    <= 3'd0;
      parity_bit <= 1'b1;
      wd_cnt     <= '0;
      byte_valid <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (shift_en) shift_reg <= {bit_in, shift_reg[7:1]};
      if (state == F_IDLE) bit_cnt <= 3'd0;
      else if (shift_en)   bit_cnt <= bit_cnt + 3'd1;
      if (parity_en) parity_bit <= bit_in;
      if (fall || state == F_IDLE) wd_cnt <= '0;
      else                         wd_cnt <= wd_cnt + 1'b1;
      byte_valid <= byte_now;
      err_q      <= err_now;
    end
  end

  assign rx_byte = shift_reg;
  assign err     = err_q | wd_hit;

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard receiver with E0/F0 prefix decoding, make/break event stream
// and a held-key bitmap for a parametrised table of tracked keys.
// Optional feature macro: PS2_PARITY_CHECK_EN (enforced in ps2_rx_frame).
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int                          NUM_KEYS    = 12,
  parameter logic [NUM_KEYS-1:0][8:0]    KEY_MAP     = ps2_pkg::DEFAULT_KEY_MAP,
  parameter int                          TIMEOUT_CYC = 50_000
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_ps2_clk,
  input  logic                i_ps2_data,
  output logic [NUM_KEYS-1:0] o_key_down,
  output logic                o_evt_valid,
  output logic [7:0]          o_evt_code,
  output logic                o_evt_ext,
  output logic                o_evt_break,
  output logic                o_frame_err
);

  logic                byte_valid, rx_err;
  logic [7:0]          rx_byte;
  dec_state_t          dec_state, dec_next;
  logic                emit, emit_ext, emit_break;
  logic [NUM_KEYS-1:0] key_match;
  logic                is_ext, is_brk;

  ps2_rx_frame #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
    .clk        (i_clk),
    .rst        (i_rst),
    .ps2_clk    (i_ps2_clk),
    .ps2_data   (i_ps2_data),
    .byte_valid (byte_valid),
    .rx_byte    (rx_byte),
    .err        (rx_err)
  );

  assign is_ext      = (rx_byte == PS2_EXT);
  assign is_brk      = (rx_byte == PS2_BRK);
  assign o_frame_err = rx_err;

  // Prefix decoder state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) dec_state <= D_IDLE;
    else       dec_state <= dec_next;
  end

  // Prefix decoder transitions; any frame error drops a pending prefix.
  always_comb begin
    dec_next = dec_state;
    if (rx_err) begin
      dec_next = D_IDLE;
    end else if (byte_valid) begin
      case (dec_state)
        D_IDLE:  dec_next = is_ext ? D_EXT : (is_brk ? D_BRK : D_IDLE);
        D_EXT:   dec_next = is_brk ? D_EXTBRK : (is_ext ? D_EXT : D_IDLE);
        default: dec_next = D_IDLE;
      endcase
    end
  end

  // Prefix decoder outputs: whether this byte completes an event, and its kind.
  always_comb begin
    emit       = 1'b0;
    emit_ext   = 1'b0;
    emit_break = 1'b0;
    if (byte_valid) begin
      case (dec_state)
        D_IDLE: emit = ~is_ext & ~is_brk;
        D_EXT: begin
          emit     = ~is_ext & ~is_brk;
          emit_ext = 1'b1;
        end
        D_BRK: begin
          emit       = 1'b1;
          emit_break = 1'b1;
        end
        D_EXTBRK: begin
          emit       = 1'b1;
          emit_ext   = 1'b1;
          emit_break = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Compare the pending event against every tracked key in parallel.
  always_comb begin
    for (int i = 0; i < NUM_KEYS; i++) begin
      key_match[i] = (KEY_MAP[i] == {emit_ext, rx_byte});
    end
  end

  // Register the event stream and apply make/break to all matching bitmap entries.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_key_down  <= '0;
      o_evt_valid <= 1'b0;
      o_evt_code  <= 8'h00;
      o_evt_ext   <= 1'b0;
      o_evt_break <= 1'b0;
    end else begin
      o_evt_valid <= emit;
      if (emit) begin
        o_evt_code  <= rx_byte;
        o_evt_ext   <= emit_ext;
        o_evt_break <= emit_break;
        o_key_down  <= emit_break ? (o_key_down & ~key_match) : (o_key_down | key_match);
      end
    end
  end

endmodule
